pipe_stage_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage MIPS core.
- Generates enable/clear controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves four events: data-memory wait, taken branch, load-use hazard and multi-cycle mul/div occupancy.
- Also keeps a saturating count of front-end stall cycles for performance monitoring.

---
 rtl/pipe_stage_ctrl.sv | 82 ++++++++
 tb/tb_pipe_stage_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: 5-stage pipeline sequencer resolving mem wait, branch, load-use and mul/div occupancy
module pipe_stage_ctrl #(
  parameter int RW = 5,
  parameter int MD_LAT = 8,
  parameter int CW = 4,
  parameter int SW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_uses_rt,
  input  logic          id_md_start,
  input  logic [RW-1:0] ex_rt,
  input  logic          ex_memread,
  input  logic          ex_branch_taken,
  input  logic          mem_req,
  input  logic          mem_ready,
  output logic          pc_en,
  output logic          ifid_en,
  output logic          idex_en,
  output logic          exmem_en,
  output logic          memwb_en,
  output logic          ifid_clr,
  output logic          idex_clr,
  output logic          exmem_clr,
  output logic          memwb_clr,
  output logic          md_busy,
  output logic [1:0]    state,
  output logic [SW-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN = 2'd0, MD_BUSY = 2'd1, MEM_WAIT = 2'd2} state_t;
  state_t st, nxt;
  logic [CW-1:0] cnt, nxt_cnt;
  logic mem_stall, load_use, md_active;
  assign mem_stall = mem_req & ~mem_ready;
  assign load_use = ex_memread & (ex_rt != '0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign md_active = (st == MD_BUSY) && (cnt != '0);
  assign state = st;
  assign md_busy = ~RST & (st == MD_BUSY);
  always_comb begin
    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'h1f;
    {ifid_clr, idex_clr, exmem_clr, memwb_clr} = 4'h0;
    nxt = RUN;
    nxt_cnt = cnt;
    if (md_active) begin
      {pc_en, ifid_en, idex_en} = 3'b000;
      exmem_en = ~mem_stall;
      exmem_clr = ~mem_stall;
      memwb_clr = mem_stall;
      nxt_cnt = cnt - 1'b1;
      nxt = MD_BUSY;
    end else if (mem_stall) begin
      {pc_en, ifid_en, idex_en, exmem_en} = 4'h0;
      memwb_clr = 1'b1;
      nxt = (st == MD_BUSY) ? MD_BUSY : MEM_WAIT;
    end else if (ex_branch_taken) begin
      {ifid_clr, idex_clr} = 2'b11;
    end else if (load_use) begin
      {pc_en, ifid_en} = 2'b00;
      idex_clr = 1'b1;
    end else if (id_md_start) begin
      nxt = MD_BUSY;
      nxt_cnt = CW'(MD_LAT - 1);
    end
    if (RST) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'h0;
      {ifid_clr, idex_clr, exmem_clr, memwb_clr} = 4'hf;
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st <= RUN;
      cnt <= '0;
      stall_cnt <= '0;
    end else begin
      st <= nxt;
      cnt <= nxt_cnt;
      if (!pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb_pipe_stage_ctrl: directed self-checking bench for pipe_stage_ctrl
module tb_pipe_stage_ctrl;
  logic CLK = 0, RST = 1;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, id_md_start, ex_memread, ex_branch_taken, mem_req, mem_ready;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_clr, idex_clr, exmem_clr, memwb_clr, md_busy;
  logic [1:0] state;
  logic [31:0] stall_cnt;
  int n_chk = 0, n_fail = 0;
  pipe_stage_ctrl dut (
    .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_md_start(id_md_start), .ex_rt(ex_rt), .ex_memread(ex_memread),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_clr(ifid_clr), .idex_clr(idex_clr), .exmem_clr(exmem_clr), .memwb_clr(memwb_clr),
    .md_busy(md_busy), .state(state), .stall_cnt(stall_cnt)
  );
  always #5 CLK = ~CLK;
  wire [4:0] ens = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
  wire [3:0] clrs = {ifid_clr, idex_clr, exmem_clr, memwb_clr};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    {id_rs, id_rt, ex_rt} = '0;
    {id_uses_rt, id_md_start, ex_memread, ex_branch_taken, mem_req, mem_ready} = '0;
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  initial begin
    idle();
    #2;
    check("rst_ens", ens, 5'h00);
    check("rst_clrs", clrs, 4'hf);
    check("rst_state", state, 0);
    check("rst_cnt", stall_cnt, 0);
    @(negedge CLK);
    RST = 0;
    #1;
    check("run_ens", ens, 5'h1f);
    check("run_clrs", clrs, 4'h0);
    step();
    ex_memread = 1; ex_rt = 5; id_rs = 5;
    #1;
    check("lu_ens", ens, 5'b00111);
    check("lu_clrs", clrs, 4'b0100);
    step();
    ex_memread = 0;
    #1;
    check("lu_after_ens", ens, 5'h1f);
    check("lu_stall", stall_cnt, 1);
    ex_memread = 1; ex_rt = 0; id_rs = 0;
    #1;
    check("lu_r0_ens", ens, 5'h1f);
    step();
    check("lu_r0_stall", stall_cnt, 1);
    ex_rt = 5; id_rs = 5; ex_branch_taken = 1;
    #1;
    check("br_lu_ens", ens, 5'h1f);
    check("br_lu_clrs", clrs, 4'b1100);
    step();
    check("br_lu_stall", stall_cnt, 1);
    ex_branch_taken = 0; id_rs = 0; ex_rt = 7; id_rt = 7; id_uses_rt = 1;
    #1;
    check("lu_rt_pc", pc_en, 0);
    step();
    check("lu_rt_stall", stall_cnt, 2);
    idle();
    id_md_start = 1;
    #1;
    check("md_issue_ens", ens, 5'h1f);
    step();
    id_md_start = 0;
    for (int i = 0; i < 7; i++) begin
      #1;
      check("md_busy", md_busy, 1);
      check("md_ens", ens, 5'b00011);
      check("md_exclr", exmem_clr, 1);
      step();
    end
    check("md_exit_ens", ens, 5'h1f);
    check("md_exit_clrs", clrs, 4'h0);
    step();
    check("md_done_state", state, 0);
    check("md_stall", stall_cnt, 9);
    id_md_start = 1;
    step();
    id_md_start = 0;
    step();
    mem_req = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("mdmw_ens", ens, 5'b00001);
      check("mdmw_wbclr", memwb_clr, 1);
      check("mdmw_exclr", exmem_clr, 0);
      step();
    end
    check("mdmw_state", state, 1);
    mem_ready = 1;
    #1;
    check("mdmw_rel_ens", ens, 5'h1f);
    check("mdmw_rel_clrs", clrs, 4'h0);
    step();
    check("mdmw_rel_state", state, 0);
    check("mdmw_stall", stall_cnt, 20);
    mem_ready = 0;
    #1;
    check("mw_ens", ens, 5'b00001);
    check("mw_wbclr", memwb_clr, 1);
    step();
    check("mw_state", state, 2);
    mem_ready = 1; ex_branch_taken = 1;
    #1;
    check("mw_br_ens", ens, 5'h1f);
    check("mw_br_clrs", clrs, 4'b1100);
    step();
    check("mw_br_state", state, 0);
    check("mw_br_stall", stall_cnt, 21);
    idle();
    id_md_start = 1;
    step();
    id_md_start = 0;
    step();
    step();
    step();
    check("rmd_state", state, 1);
    RST = 1;
    #1;
    check("rmd_state0", state, 0);
    check("rmd_busy", md_busy, 0);
    check("rmd_stall", stall_cnt, 0);
    check("rmd_clrs", clrs, 4'hf);
    check("rmd_ens", ens, 5'h00);
    @(negedge CLK);
    RST = 0;
    step();
    check("post_rst_state", state, 0);
    check("post_rst_ens", ens, 5'h1f);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
